// File: rtl/dl_pkg.sv
// Shared types and encodings for the multi-bank data loader.
package dl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2
    } dl_state_e;

    localparam logic [2:0] LOAD_STATE      = 3'd1;
    localparam logic       MODE_INTERLEAVE = 1'b0;
    localparam logic       MODE_BROADCAST  = 1'b1;

endpackage

// File: rtl/syncSRAM.sv
// Single-port-write / single-port-read synchronous SRAM bank, read-first on collision.
module syncSRAM #(
    parameter int DW = 256,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd,
    input  logic          re,
    input  logic [AW-1:0] ra,
    output logic [DW-1:0] rd
);

    logic [DW-1:0] mem_r [0:(1<<AW)-1];

    // Storage write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[wa] <= wd;
        end
    end

    // Registered read; non-blocking update yields the pre-write word on a same-address collision
    always_ff @(posedge clk) begin
        if (re) begin
            rd <= mem_r[ra];
        end
    end

endmodule

// File: rtl/data_loader_mb.sv
// Streams AXI-stream beats into NB SRAM banks, either interleaved across banks or broadcast to all.
module data_loader_mb
    import dl_pkg::*;
#(
    parameter int DW = 256,
    parameter int AW = 8,
    parameter int NB = 4,
    parameter int CW = AW + $clog2(NB)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       top_level_state,
    input  logic             start,
    input  logic             mode,
    input  logic [AW-1:0]    base_addr,
    input  logic [CW-1:0]    num_beats,
    input  logic             t_valid,
    input  logic [DW-1:0]    t_data,
    input  logic             t_last,
    output logic             t_ready,
    input  logic [NB-1:0]    rd_re,
    input  logic [NB*AW-1:0] rd_ra,
    output logic [NB*DW-1:0] rd_data,
    output logic             busy,
    output logic             done,
    output logic             err_short,
    output logic             err_long
);

    localparam int LB = $clog2(NB);

    logic [1:0]    rst_sync_r;
    logic          rst_n_s;
    logic [1:0]    state_r;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] nbeats_r;
    logic [AW-1:0] base_r;
    logic          mode_r;
    logic          err_short_r;
    logic          err_long_r;
    logic [NB-1:0] we_r;
    logic [AW-1:0] wa_r;
    logic [DW-1:0] wd_r;
    logic          hs_s;
    logic          final_s;
    logic [NB-1:0] we_s;
    logic [AW-1:0] wa_s;

    // Reset asserts immediately but releases on a clock edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_sync_r <= 2'b00;
        end else begin
            rst_sync_r <= {rst_sync_r[0], 1'b1};
        end
    end

    assign rst_n_s   = rst_sync_r[1];
    assign t_ready   = (state_r == ST_LOAD) && (top_level_state == LOAD_STATE);
    assign hs_s      = t_valid && t_ready;
    assign final_s   = (cnt_r == nbeats_r);
    assign busy      = (state_r == ST_LOAD) || (state_r == ST_FLUSH);
    assign done      = (state_r == ST_FLUSH);
    assign err_short = err_short_r;
    assign err_long  = err_long_r;

    // Bank select and address for the beat currently on the stream
    always_comb begin
        we_s = {NB{1'b0}};
        wa_s = {AW{1'b0}};
        if (mode_r == MODE_BROADCAST) begin
            we_s = {NB{1'b1}};
            wa_s = base_r + cnt_r[AW-1:0];
        end else begin
            we_s[cnt_r[LB-1:0]] = 1'b1;
            wa_s = base_r + cnt_r[CW-1:LB];
        end
    end

    // Transfer control FSM; a stalled LOAD simply sees no handshakes
    always_ff @(posedge clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CW{1'b0}};
            nbeats_r    <= {CW{1'b0}};
            base_r      <= {AW{1'b0}};
            mode_r      <= MODE_INTERLEAVE;
            err_short_r <= 1'b0;
            err_long_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r     <= ST_LOAD;
                        cnt_r       <= {CW{1'b0}};
                        nbeats_r    <= num_beats;
                        base_r      <= base_addr;
                        mode_r      <= mode;
                        err_short_r <= 1'b0;
                        err_long_r  <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (hs_s) begin
                        cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                        if (final_s) begin
                            state_r <= ST_FLUSH;
                            if (!t_last) begin
                                err_long_r <= 1'b1;
                            end
                        end else if (t_last) begin
                            state_r     <= ST_FLUSH;
                            err_short_r <= 1'b1;
                        end
                    end
                end
                ST_FLUSH: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Write pipeline: the SRAM sees each beat one cycle after its handshake
    always_ff @(posedge clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            we_r <= {NB{1'b0}};
            wa_r <= {AW{1'b0}};
            wd_r <= {DW{1'b0}};
        end else begin
            we_r <= hs_s ? we_s : {NB{1'b0}};
            if (hs_s) begin
                wa_r <= wa_s;
                wd_r <= t_data;
            end
        end
    end

    for (genvar b = 0; b < NB; b++) begin : g_bank
        syncSRAM #(
            .DW(DW),
            .AW(AW)
        ) u_sram (
            .clk(clk),
            .we (we_r[b]),
            .wa (wa_r),
            .wd (wd_r),
            .re (rd_re[b]),
            .ra (rd_ra[b*AW +: AW]),
            .rd (rd_data[b*DW +: DW])
        );
    end

endmodule

// File: tb/tb_data_loader_mb.sv
// Randomized scoreboard bench for data_loader_mb against an address-rule memory model.
module tb_data_loader_mb;

    localparam int DW = 256;
    localparam int AW = 8;
    localparam int NB = 4;
    localparam int CW = AW + 2;
    localparam int DEPTH = 256;

    logic             clk = 1'b0;
    logic             rst;
    logic [2:0]       tls;
    logic             start, mode, t_valid, t_last, t_ready;
    logic [AW-1:0]    base_addr;
    logic [CW-1:0]    num_beats;
    logic [DW-1:0]    t_data;
    logic [NB-1:0]    rd_re;
    logic [NB*AW-1:0] rd_ra;
    logic [NB*DW-1:0] rd_data;
    logic             busy, done, err_short, err_long;

    always #5 clk = ~clk;

    data_loader_mb #(.DW(DW), .AW(AW), .NB(NB), .CW(CW)) dut (
        .clk(clk), .rst(rst), .top_level_state(tls), .start(start), .mode(mode),
        .base_addr(base_addr), .num_beats(num_beats), .t_valid(t_valid), .t_data(t_data),
        .t_last(t_last), .t_ready(t_ready), .rd_re(rd_re), .rd_ra(rd_ra), .rd_data(rd_data),
        .busy(busy), .done(done), .err_short(err_short), .err_long(err_long)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct { int b; logic [DW-1:0] d; } rd_exp_t;
    typedef struct { int c; bit es; bit el; } done_exp_t;
    rd_exp_t   rdq[$];
    done_exp_t dq[$];
    rd_exp_t   re_e;
    done_exp_t de_e;

    logic [DW-1:0] mem_m   [NB][DEPTH];
    bit            valid_m [NB][DEPTH];
    bit            pw_v;
    bit            pw_b [NB];
    int            pw_a;
    logic [DW-1:0] pw_d;

    logic [NB-1:0] re_seen = '0;
    logic [DW-1:0] last_rd [NB];
    bit            seen [NB];

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) re_seen <= rd_re;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares read data and done pulses as the DUT presents them
    always @(negedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (re_seen[b]) begin
                if (rdq.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL rd_unexpected: bank %0d got data with no expected entry", b);
                end else begin
                    re_e = rdq.pop_front();
                    chk("rd_bank", b, re_e.b);
                    chk("rd_data", rd_data[b*DW +: DW], re_e.d);
                end
                last_rd[b] = rd_data[b*DW +: DW];
                seen[b] = 1'b1;
            end else if (seen[b]) begin
                chk("rd_hold", rd_data[b*DW +: DW], last_rd[b]);
            end
        end
        if (done === 1'b1) begin
            if (dq.size() == 0) begin
                checks++; failures++;
                $display("FAIL done_unexpected: got done=1 expected 0 at cycle %0d", cyc);
            end else begin
                de_e = dq.pop_front();
                chk("done_cycle", cyc, de_e.c);
                chk("err_short", err_short, de_e.es);
                chk("err_long", err_long, de_e.el);
            end
        end
    end

    task automatic apply_pending();
        if (pw_v) begin
            for (int b = 0; b < NB; b++) begin
                if (pw_b[b]) begin
                    mem_m[b][pw_a] = pw_d;
                    valid_m[b][pw_a] = 1'b1;
                end
            end
            pw_v = 1'b0;
        end
    endtask

    // Beat k lands in bank k%NB at base+k/NB (interleave) or every bank at base+k (broadcast)
    task automatic record_beat(input bit md, input int base, input int k, input logic [DW-1:0] d);
        pw_v = 1'b1;
        for (int b = 0; b < NB; b++) pw_b[b] = md;
        if (md) pw_a = (base + k) % DEPTH;
        else begin
            pw_b[k % NB] = 1'b1;
            pw_a = (base + k / NB) % DEPTH;
        end
        pw_d = d;
    endtask

    task automatic xfer(input bit md, input int base, input int nb, input int last_at, input bit drop_last,
                        input int stall_at, input int stall_len, input bit coinc, input int rst_at, input bit fixed);
        int k = 0;
        int stalled = 0;
        int guard = 0;
        bit fin = 0, gapped = 0, spur = 0, aborted = 0, hs, exp_ready;
        logic [DW-1:0] d;
        @(negedge clk);
        start = 1'b1; mode = md; base_addr = AW'(base); num_beats = CW'(nb);
        @(negedge clk);
        start = 1'b0; mode = 1'($urandom); base_addr = AW'($urandom); num_beats = CW'($urandom);
        while (!fin && guard < 500) begin
            guard++;
            apply_pending();
            tls = 3'd1;
            t_valid = ($urandom_range(0, 3) != 0);
            start = (k == 1) && !spur;
            if (start) spur = 1'b1;
            if (k == stall_at && stalled < stall_len) begin
                tls = 3'd2; t_valid = 1'b1; stalled++;
            end
            d = fixed ? DW'(k) : {$urandom(), $urandom(), $urandom(), $urandom(),
                                  $urandom(), $urandom(), $urandom(), $urandom()};
            t_data = d;
            t_last = (k == last_at) || (k == nb && !drop_last);
            if (k == rst_at) begin
                if (!gapped) begin
                    t_valid = 1'b0; gapped = 1'b1;
                end else begin
                    t_valid = 1'b1; rst = 1'b0; #1;
                    chk("rst_t_ready", t_ready, 0);
                    chk("rst_busy", busy, 0);
                    chk("rst_done", done, 0);
                    chk("rst_err_short", err_short, 0);
                    chk("rst_err_long", err_long, 0);
                    aborted = 1'b1;
                    break;
                end
            end
            #1;
            exp_ready = (tls == 3'd1);
            chk("t_ready", t_ready, exp_ready);
            chk("busy_load", busy, 1);
            hs = t_valid && exp_ready;
            if (hs) begin
                record_beat(md, base, k, d);
                if (k == nb || k == last_at) begin
                    fin = 1'b1;
                    dq.push_back('{cyc + 1, (k < nb), (k == nb && drop_last)});
                end
                k++;
            end
            @(negedge clk);
        end
        start = 1'b0;
        if (!fin && !aborted) begin
            checks++; failures++;
            $display("FAIL xfer_timeout: got %0d beats expected %0d", k, nb + 1);
        end
        if (aborted) begin
            repeat (2) @(negedge clk);
            rst = 1'b1; t_valid = 1'b0; t_last = 1'b0;
            repeat (4) @(negedge clk);
            chk("post_rst_busy", busy, 0);
            chk("post_rst_t_ready", t_ready, 0);
        end else begin
            if (coinc) begin
                rd_re = '0; rd_re[0] = 1'b1; rd_ra[0 +: AW] = 8'h20;
                rdq.push_back('{0, mem_m[0][32]});
            end
            apply_pending();
            t_valid = 1'b0; t_last = 1'b0; #1;
            chk("flush_t_ready", t_ready, 0);
            chk("flush_busy", busy, 1);
            @(negedge clk); rd_re = '0; #1;
            chk("idle_busy", busy, 0);
            chk("idle_t_ready", t_ready, 0);
            @(negedge clk);
            chk("done_seen", dq.size(), 0);
        end
    endtask

    task automatic read1(input int b, input int a, input logic [DW-1:0] exp);
        @(negedge clk);
        rd_re = '0; rd_re[b] = 1'b1; rd_ra[b*AW +: AW] = AW'(a);
        rdq.push_back('{b, exp});
        @(negedge clk); rd_re = '0;
        @(negedge clk);
    endtask

    // Reads back every word the model knows, all banks in parallel per address
    task automatic sweep();
        bit any;
        for (int a = 0; a < DEPTH; a++) begin
            any = 1'b0;
            for (int b = 0; b < NB; b++) if (valid_m[b][a]) any = 1'b1;
            if (any) begin
                @(negedge clk);
                rd_re = '0;
                for (int b = 0; b < NB; b++) begin
                    if (valid_m[b][a]) begin
                        rd_re[b] = 1'b1; rd_ra[b*AW +: AW] = AW'(a);
                        rdq.push_back('{b, mem_m[b][a]});
                    end
                end
            end
        end
        @(negedge clk); rd_re = '0;
        repeat (2) @(negedge clk);
        chk("rdq_drained", rdq.size(), 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int md, base, nb, la, sa;
        rst = 1'b1; tls = 3'd1; start = 1'b0; mode = 1'b0; base_addr = '0; num_beats = '0;
        t_valid = 1'b0; t_data = '0; t_last = 1'b0; rd_re = '0; rd_ra = '0;
        pw_v = 1'b0;
        for (int b = 0; b < NB; b++) begin
            seen[b] = 1'b0;
            for (int a = 0; a < DEPTH; a++) valid_m[b][a] = 1'b0;
        end
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_t_ready", t_ready, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_err_short", err_short, 0);
        chk("reset_err_long", err_long, 0);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        xfer(0, 'h10, 7, -1, 0, -1, 0, 0, -1, 1);
        read1(1, 'h10, 256'd1);
        read1(3, 'h11, 256'd7);
        sweep();

        xfer(1, 'hFE, 3, -1, 0, -1, 0, 0, -1, 1);
        read1(2, 'h00, 256'd2);
        read1(0, 'h01, 256'd3);
        read1(3, 'hFE, 256'd0);
        sweep();

        xfer(0, 'h10, 5, 2, 0, -1, 0, 0, -1, 0);
        sweep();
        xfer(0, 'h40, 9, -1, 0, 3, 5, 0, -1, 0);
        sweep();
        xfer(1, 'h60, 4, -1, 1, -1, 0, 0, -1, 0);
        sweep();
        xfer(0, 'h80, 7, -1, 0, -1, 0, 0, 4, 0);
        sweep();
        xfer(1, 'h90, 6, -1, 0, 2, 3, 0, -1, 0);
        sweep();

        xfer(0, 'h20, 0, -1, 0, -1, 0, 0, -1, 0);
        xfer(0, 'h20, 0, -1, 0, -1, 0, 1, -1, 0);
        sweep();

        for (int i = 0; i < 8; i++) begin
            md = $urandom_range(0, 1);
            base = $urandom_range(0, 255);
            nb = $urandom_range(0, 20);
            la = ($urandom_range(0, 2) == 0 && nb > 0) ? $urandom_range(0, nb - 1) : -1;
            sa = ($urandom_range(0, 1) == 0) ? $urandom_range(0, nb) : -1;
            xfer(md[0], base, nb, la, ($urandom_range(0, 3) == 0), sa, $urandom_range(1, 6), 0, -1, 0);
            sweep();
        end

        chk("done_queue_empty", dq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_loader_mb.md
DATA_LOADER_MB -- requirements
Module: data_loader_mb

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- DW, 256, data width
- AW, 8, per-bank address width
- NB, 4, bank count (power of 2, >=2)
- CW, AW+$clog2(NB), beat-counter width
REQ-002 clk  in  1  clock; all logic on rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 top_level_state  in  3  global state; load enabled only when equal to LOAD_STATE.
REQ-005 start  in  1  one-cycle pulse; arms a transfer.
REQ-006 mode  in  1  0 = interleave (beat k to bank k mod NB), 1 = broadcast (every beat to all banks); sampled at start.
REQ-007 base_addr  in  AW  start address in each bank; sampled at start.
REQ-008 num_beats  in  CW  beats minus 1; sampled at start.
REQ-009 t_valid, t_data, t_last  in  1, DW, 1  AXI-stream slave inputs.
REQ-010 t_ready  out  1  AXI-stream ready.
REQ-011 rd_re  in  NB  per-bank read enable.
REQ-012 rd_ra  in  NB*AW  per-bank read addresses; bank b at [b*AW +: AW].
REQ-013 rd_data  out  NB*DW  per-bank read data; bank b at [b*DW +: DW].
REQ-014 busy  out  1  high in LOAD and FLUSH.
REQ-015 done  out  1  one-cycle pulse at transfer end.
REQ-016 err_short, err_long  out  1, 1  sticky tlast-mismatch flags; cleared by start.

Function
REQ-020 FSM states SHALL be IDLE, LOAD, FLUSH.
- IDLE->LOAD on start.
- LOAD->FLUSH on the handshake of the final beat, or on an early t_last.
- FLUSH->IDLE after one cycle, asserting done in that cycle.
REQ-021 start in LOAD or FLUSH SHALL be ignored; no parameter is resampled.
REQ-022 t_ready SHALL be 1 only in LOAD with top_level_state==LOAD_STATE; otherwise 0, including in IDLE.
REQ-023 A handshake is t_valid & t_ready; only a handshake SHALL increment beat counter cnt (reset and start value 0).
REQ-024 Stall: if top_level_state leaves LOAD_STATE while in LOAD, the FSM SHALL hold, with cnt and all flags frozen, and resume when it returns.
REQ-025 Interleave: write bank = cnt[log2NB-1:0]; address = base_addr + cnt[CW-1:log2NB], modulo 2^AW (wrap, no error).
REQ-026 Broadcast: all NB banks written at base_addr + cnt[AW-1:0], modulo 2^AW.
REQ-027 Write path SHALL be registered: SRAM write occurs 1 cycle after the handshake; we, wa and wd are all flopped, with no latches.
REQ-028 The final beat is the one where cnt==num_beats; num_beats=0 SHALL give a one-beat transfer.
REQ-029 t_last on a beat before the final one SHALL set err_short and end the transfer; that beat is still written.
REQ-030 Final beat without t_last SHALL set err_long; the transfer still ends.
REQ-031 Read port: rd_data[b] SHALL be valid 1 cycle after rd_re[b]; rd_data SHALL hold when rd_re is low.
REQ-032 Same-cycle read and write to the same bank address SHALL return the old data (read-first).
REQ-033 done and the final SRAM write SHALL occur in the same cycle (FLUSH), so data is readable from the cycle after done.

Reset
REQ-040 On rst low, outputs and state SHALL reset asynchronously:
- FSM to IDLE
- cnt = 0
- t_ready, busy, done, err_short, err_long = 0
- pending write cancelled
REQ-041 Reset mid-transfer SHALL abort without a further SRAM write; SRAM contents are not cleared; rd_data is undefined until the first read after reset.
REQ-042 Reset deassertion SHALL be synchronous to clk.

Structure
REQ-050 Package dl_pkg SHALL hold the FSM state enum, LOAD_STATE = 3'd1 and the mode encodings.
REQ-051 Each bank SHALL be an instance of the existing syncSRAM (DW, AW) in a generate loop; no other sub-module.

Verification
REQ-060 Interleave, NB=4, base=0x10, num_beats=7, data 0..7, t_last on beat 7 -> bank1 addr 0x10=1, bank3 addr 0x11=7; done once; errors 0.
REQ-061 Broadcast, base=0xFE, num_beats=3 -> all banks addr 0xFE,0xFF,0x00,0x01 = beats 0..3 (wrap).
REQ-062 t_last on beat 2 of num_beats=5 -> err_short=1; 3 beats written; done; t_ready=0 afterwards.
REQ-063 top_level_state=2 for 5 cycles mid-transfer -> t_ready=0, no writes, cnt frozen; completes correctly after return.
REQ-064 rst low on beat 4 of 8 -> IDLE next edge, no write for beat 4; new start loads cleanly.
REQ-065 Read and write to bank0 addr 0x20 in the same cycle -> old value returned; new value on the next read.
